rf_burst_reader: RTL
====================

Name: rf_burst_reader

Overview:
- Read-side sequencer for the multi-ported register file: the reader that pairs with the file's single write port.
- Accepts a burst request (start index, length), drives one register-file read port with a stepping address, and streams the words out over a valid/ready interface through a 2-entry output buffer.
- Used to walk stored tables (e.g. round keys) into datapath consumers at one word per cycle.

Parameters:
addr_width, 4, width of register-file index and req_addr
data_width, 128, width of each stored word
lo, 0, lowest valid register-file index
hi, 10, highest valid register-file index

Ports:
CLK  input  1  clock, all state updates on posedge
RST_N  input  1  reset, synchronous, active-low
req_valid  input  1  burst request present
req_ready  output  1  request accepted when req_valid&&req_ready
req_addr  input  addr_width  start index of burst
req_len  input  addr_width+1  beat count, 0..hi-lo+1
rf_addr  output  addr_width  to register-file ADDR_n read port
rf_data  input  data_width  from matching D_OUT_n (combinational)
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts beat
out_data  output  data_width  read word
out_last  output  1  final beat of burst
busy  output  1  burst in progress or buffer non-empty
done  output  1  one-cycle pulse after last beat handshaked
err  output  1  one-cycle pulse: request rejected as out of range

Behaviour:
- Reset: when RST_N=0 at posedge, go to IDLE, empty buffer, clear counters. req_ready=1 after reset; out_valid, out_last, busy, done, err=0; rf_addr=lo. Reset mid-burst discards all remaining and buffered beats, with no done pulse.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - req_ready=1.
  - On handshake with req_addr<lo, req_addr>hi, or req_len>hi-lo+1: pulse err next cycle, emit no beats, stay IDLE.
  - On handshake with req_len=0: pulse done next cycle, stay IDLE.
  - Otherwise: load cur=req_addr, rem=req_len, go to RUN.
- RUN:
  - req_ready=0; rf_addr=cur.
  - Capture condition, each cycle: buffer count<2, or count=2 with a pop this cycle.
  - On capture: push {rf_data, last=(rem==1)}, decrement rem, advance cur. cur wraps hi->lo.
  - After the push with rem==1, go to DRAIN.
- DRAIN: req_ready=0. When the buffer empties via the last-beat handshake, pulse done and go to IDLE. The next request can be accepted the cycle after done.
- Buffer: 2-entry FIFO. out_valid=count!=0. out_data/out_last come from the head. Push and pop in the same cycle are legal at any count, including full.
- Latency and throughput: request handshake at cycle N -> first out_valid at N+2 (N+1 loads RUN, N+1 capture registers into buffer). With out_ready held high, one beat per cycle and no bubbles.
- Backpressure: out_ready low holds the head stable. out_data and out_last must not change while out_valid && !out_ready.
- Data coherency: the word is sampled at capture. A register-file write in the same cycle to the same index is not visible; the old value is returned.
- busy = (state!=IDLE).
- done and err are never both asserted in the same cycle.

Decomposition:
- Shared package: FSM state encoding (IDLE/RUN/DRAIN), beat record type {data, last}, and an index-wrap helper function (cur==hi ? lo : cur+1).
- One sub-module: rf_burst_skid2, a parameterised 2-entry valid/ready FIFO of width data_width+1. It is reusable by other readers.

Test Plan:
1. lo=0, hi=10, file holds word[i]=i. Request addr=2, len=4, out_ready=1 -> beats 2,3,4,5 on consecutive cycles starting 2 cycles after handshake; out_last only on 5; done pulse the cycle after 5 handshakes.
2. Request addr=9, len=4 -> beats 9,10,0,1 (wrap hi->lo); out_last on 1.
3. Request addr=0, len=6 with out_ready toggling 1,0,0,1,... -> no beat lost or duplicated, out_data stable while stalled, sequence 0..5, at most 2 beats buffered.
4. Request addr=11 (or len=12) -> err pulse, no out_valid, req_ready stays 1. Request len=0 -> done pulse only.
5. Assert RST_N=0 for one cycle after the 2nd beat of addr=0, len=8 -> out_valid=0, busy=0, no done; a following request addr=3, len=1 returns 3 normally.
6. During a burst over index 4, write 0xAA to index 4 in the capture cycle -> burst returns old value 4; a second burst returns 0xAA.

Source files
------------

// File: rtl/rf_burst_reader_pkg.sv
// Shared types for the register-file burst reader: FSM encoding, the beat
// record carried through the output buffer, and the index-wrap helper.
package rf_burst_reader_pkg;

    localparam int RF_ADDR_WIDTH = 4;
    localparam int RF_DATA_WIDTH = 128;
    localparam int RF_LO         = 0;
    localparam int RF_HI         = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [RF_DATA_WIDTH-1:0] data;
        logic                     last;
    } beat_t;

    localparam int BEAT_WIDTH = $bits(beat_t);

    // Next register-file index, wrapping from the top of the window back to its base.
    function automatic int wrap_next(input int cur, input int lo, input int hi);
        return (cur == hi) ? lo : cur + 1;
    endfunction

endpackage

// File: rtl/rf_burst_reader_if.sv
// Request, register-file read port and output stream of the burst reader.
// The slave modport is the reader's view; master is the requester/consumer side.
interface rf_burst_reader_if
    import rf_burst_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH:0]   req_len;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport slave (
        input  req_valid, req_addr, req_len, rf_data, out_ready,
        output req_ready, rf_addr, out_valid, out_data, out_last, busy, done, err
    );

    modport master (
        output req_valid, req_addr, req_len, rf_data, out_ready,
        input  req_ready, rf_addr, out_valid, out_data, out_last, busy, done, err
    );

endinterface

// File: rtl/rf_burst_skid2.sv
// Two-entry valid/ready FIFO. Push and pop may happen together at any fill
// level, including full, so a full buffer still streams one word per cycle.
module rf_burst_skid2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             push;
    logic             pop;

    assign out_valid_o = (count_q != 2'd0);
    assign pop         = out_valid_o && out_ready_i;
    assign in_ready_o  = (count_q != 2'd2) || out_ready_i;
    assign push        = in_valid_i && in_ready_o;
    assign out_data_o  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // When full, the write slot is the head slot being popped this same cycle.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/rf_burst_reader.sv
// Burst read sequencer: steps one register-file read port across a wrapping
// index window and streams the words out through a 2-entry buffer.
module rf_burst_reader
    import rf_burst_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int LO         = RF_LO,
    parameter int HI         = RF_HI
) (
    input  logic              CLK,
    input  logic              RST_N,
    rf_burst_reader_if.slave  bus
);

    localparam int                  SPAN    = HI - LO + 1;
    localparam logic [ADDR_WIDTH:0] REM_ONE = (ADDR_WIDTH+1)'(1);

    state_e                state_q;
    state_e                state_d;
    logic [ADDR_WIDTH-1:0] cur_q;
    logic [ADDR_WIDTH-1:0] cur_d;
    logic [ADDR_WIDTH:0]   rem_q;
    logic [ADDR_WIDTH:0]   rem_d;
    logic                  done_q;
    logic                  done_d;
    logic                  err_q;
    logic                  err_d;

    logic                  req_in_range;
    logic                  push_valid;
    logic                  push_ready;
    logic                  head_valid;
    beat_t                 push_beat;
    beat_t                 head_beat;

    assign req_in_range = (int'(bus.req_addr) >= LO) &&
                          (int'(bus.req_addr) <= HI) &&
                          (int'(bus.req_len)  <= SPAN);

    // The word is sampled at the capture edge, so a same-cycle write is not seen.
    assign push_beat.data = bus.rf_data;
    assign push_beat.last = (rem_q == REM_ONE);

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        rem_d         = rem_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        push_valid    = 1'b0;
        bus.req_ready = 1'b0;
        bus.rf_addr   = ADDR_WIDTH'(LO);
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (!req_in_range) begin
                        err_d = 1'b1;
                    end else if (bus.req_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cur_d   = bus.req_addr;
                        rem_d   = bus.req_len;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                bus.rf_addr = cur_q;
                push_valid  = 1'b1;
                if (push_ready) begin
                    rem_d = rem_q - REM_ONE;
                    cur_d = ADDR_WIDTH'(wrap_next(int'(cur_q), LO, HI));
                    if (rem_q == REM_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Nothing is pushed here, so popping the last beat empties the buffer.
                if (head_valid && bus.out_ready && head_beat.last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cur_q   <= ADDR_WIDTH'(LO);
            rem_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    rf_burst_skid2 #(
        .WIDTH (BEAT_WIDTH)
    ) u_buf (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .in_valid_i  (push_valid),
        .in_ready_o  (push_ready),
        .in_data_i   (push_beat),
        .out_valid_o (head_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (head_beat)
    );

    assign bus.out_valid = head_valid;
    assign bus.out_data  = head_beat.data;
    assign bus.out_last  = head_beat.last;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule
